// File: rtl/hazard_pkg.sv
// ---------------------------------------------------------------------------
// hazard_pkg
// Shared definitions for the pipeline hazard controller.
//   - hz_state_e : controller FSM state (RUN, MDU_WAIT)
//   - X0         : index of the hard-wired zero register
//   - NOP_INSN   : encoding that a flushed pipeline register represents
// ---------------------------------------------------------------------------
package hazard_pkg;

   // RUN is the normal flowing pipeline; MDU_WAIT means a multi-cycle
   // MUL/DIV currently owns the EX stage.
   typedef enum logic [0:0] {
      RUN      = 1'b0,
      MDU_WAIT = 1'b1
   } hz_state_e;

   // x0 is hard-wired to zero, so a load targeting it can never create a
   // true data dependence.
   localparam logic [4:0] X0 = 5'd0;

   // A *_flush output makes the pipeline register load a bubble. The
   // datapath realises the bubble as the canonical NOP (addi x0, x0, 0)
   // with all side-effect controls (reg write, mem access) cleared.
   localparam logic [31:0] NOP_INSN = 32'h0000_0013;

endpackage

// File: rtl/sat_counter.sv
// ---------------------------------------------------------------------------
// sat_counter
// Saturating up-counter used for the hazard performance counters.
//   clk   in   clock
//   rstn  in   asynchronous active-low reset, clears the count
//   inc   in   increment request for this cycle
//   count out  current count, sticks at all-ones instead of wrapping
// ---------------------------------------------------------------------------
module sat_counter #(
   parameter int W = 32
) (
   input  logic         clk,
   input  logic         rstn,
   input  logic         inc,
   output logic [W-1:0] count
);

   logic [W-1:0] count_q;
   logic [W-1:0] count_d;

   // Next value: step by one unless the counter is already saturated.
   always_comb begin
      count_d = count_q;
      if (inc && (count_q != {W{1'b1}})) begin
         count_d = count_q + W'(1);
      end
   end

   // Count register, cleared asynchronously.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q <= '0;
      end else begin
         count_q <= count_d;
      end
   end

   assign count = count_q;

endmodule

// File: rtl/hazard_ctrl.sv
// ---------------------------------------------------------------------------
// hazard_ctrl
// Central hazard controller of the 5-stage core. Produces write enables and
// bubble (flush) controls for PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
//   clk, rstn                 clock, asynchronous active-low reset
//   id_rs1/id_rs2             sources of the instruction in ID
//   id_use_rs1/id_use_rs2     ID instruction really reads that source
//   ex_memread, ex_rd         EX holds a load, and its destination
//   ex_redirect               taken branch / jump resolved in EX
//   ex_mdu_start, mdu_done    MUL/DIV start (first cycle) and completion
//   mem_req, mem_ready        data-memory access in MEM and its completion
//   *_we, *_flush             pipeline register update / bubble controls
//   stall_cnt, flush_cnt      saturating counts of stall cycles / redirects
// ---------------------------------------------------------------------------
module hazard_ctrl
   import hazard_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic             clk,
   input  logic             rstn,
   input  logic [4:0]       id_rs1,
   input  logic [4:0]       id_rs2,
   input  logic             id_use_rs1,
   input  logic             id_use_rs2,
   input  logic             ex_memread,
   input  logic [4:0]       ex_rd,
   input  logic             ex_redirect,
   input  logic             ex_mdu_start,
   input  logic             mdu_done,
   input  logic             mem_req,
   input  logic             mem_ready,
   output logic             pc_we,
   output logic             if_id_we,
   output logic             id_ex_we,
   output logic             ex_mem_we,
   output logic             mem_wb_we,
   output logic             if_id_flush,
   output logic             id_ex_flush,
   output logic             ex_mem_flush,
   output logic             mem_wb_flush,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   hz_state_e state_q;
   hz_state_e state_d;

   logic mem_wait;
   logic mdu_busy;
   logic load_use;
   logic redirect_taken;
   logic stall_inc;

   // Hazard detection terms. A start and done in the same cycle is a
   // single-cycle op and never occupies EX beyond that cycle.
   always_comb begin
      mem_wait = mem_req && !mem_ready;
      mdu_busy = ((state_q == RUN) && ex_mdu_start && !mdu_done) ||
                 ((state_q == MDU_WAIT) && !mdu_done);
      load_use = ex_memread && (ex_rd != X0) &&
                 ((id_use_rs1 && (id_rs1 == ex_rd)) ||
                  (id_use_rs2 && (id_rs2 == ex_rd)));
   end

   // Priority-ordered control generation: memory wait freezes everything,
   // then MDU occupancy, then redirect, then load-use. A redirect hidden
   // behind a freeze is neither applied nor counted; EX holds it until the
   // first unfrozen cycle. In reset all controls are forced inactive.
   always_comb begin
      pc_we          = 1'b1;
      if_id_we       = 1'b1;
      id_ex_we       = 1'b1;
      ex_mem_we      = 1'b1;
      mem_wb_we      = 1'b1;
      if_id_flush    = 1'b0;
      id_ex_flush    = 1'b0;
      ex_mem_flush   = 1'b0;
      mem_wb_flush   = 1'b0;
      redirect_taken = 1'b0;
      state_d        = state_q;

      if (!rstn) begin
         pc_we     = 1'b0;
         if_id_we  = 1'b0;
         id_ex_we  = 1'b0;
         ex_mem_we = 1'b0;
         mem_wb_we = 1'b0;
         state_d   = RUN;
      end else if (mem_wait) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_we     = 1'b0;
         ex_mem_we    = 1'b0;
         mem_wb_flush = 1'b1;
         // The MDU keeps its result until EX/MEM can take it, so a done
         // during the freeze still ends the MUL/DIV occupancy.
         if ((state_q == MDU_WAIT) && mdu_done) begin
            state_d = RUN;
         end
      end else if (mdu_busy) begin
         pc_we        = 1'b0;
         if_id_we     = 1'b0;
         id_ex_we     = 1'b0;
         ex_mem_flush = 1'b1;
         if (state_q == RUN) begin
            state_d = MDU_WAIT;
         end
      end else begin
         // Reaching here from MDU_WAIT means mdu_done is high: the result
         // advances normally this cycle.
         if (state_q == MDU_WAIT) begin
            state_d = RUN;
         end
         if (ex_redirect) begin
            if_id_flush    = 1'b1;
            id_ex_flush    = 1'b1;
            redirect_taken = 1'b1;
         end else if (load_use) begin
            pc_we       = 1'b0;
            if_id_we    = 1'b0;
            id_ex_flush = 1'b1;
         end
      end
   end

   // FSM state register; reset aborts any MUL/DIV wait immediately.
   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Every cycle out of reset in which the PC is held counts as a stall.
   assign stall_inc = rstn && !pc_we;

   sat_counter #(.W(CNT_W)) u_stall_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (stall_inc),
      .count (stall_cnt)
   );

   sat_counter #(.W(CNT_W)) u_flush_cnt (
      .clk   (clk),
      .rstn  (rstn),
      .inc   (redirect_taken),
      .count (flush_cnt)
   );

endmodule

// File: tb/tb_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_hazard_ctrl
// Directed-vector scoreboard bench for hazard_ctrl. Each vector is driven
// just after a rising edge and its hand-computed expected controls and
// counter values are queued; a monitor samples on the falling edge.
// A standalone 2-bit sat_counter checks saturation.
// ---------------------------------------------------------------------------
module tb_hazard_ctrl;

   logic        clk;
   logic        rstn;
   logic [4:0]  id_rs1, id_rs2;
   logic        id_use_rs1, id_use_rs2;
   logic        ex_memread;
   logic [4:0]  ex_rd;
   logic        ex_redirect, ex_mdu_start, mdu_done;
   logic        mem_req, mem_ready;
   logic        pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we;
   logic        if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush;
   logic [31:0] stall_cnt, flush_cnt;

   logic        satRstn, satInc;
   logic [1:0]  satCount;

   // Control bundle order: pc, if_id, id_ex, ex_mem, mem_wb we; then
   // if_id, id_ex, ex_mem, mem_wb flush.
   localparam logic [8:0] RST  = 9'b00000_0000;
   localparam logic [8:0] NORM = 9'b11111_0000;
   localparam logic [8:0] LU   = 9'b00111_0100;
   localparam logic [8:0] MDU  = 9'b00011_0010;
   localparam logic [8:0] RED  = 9'b11111_1100;
   localparam logic [8:0] MEMW = 9'b00001_0001;

   typedef struct {
      int          id;
      logic [8:0]  ctrl;
      logic [31:0] stall;
      logic [31:0] flush;
   } exp_t;

   exp_t expQ[$];
   logic [1:0] satQ[$];
   logic vecValid;
   logic satValid;
   int   vecIdx;
   int   errors;
   int   checks;

   hazard_ctrl #(.CNT_W(32)) dut (
      .clk          (clk),
      .rstn         (rstn),
      .id_rs1       (id_rs1),
      .id_rs2       (id_rs2),
      .id_use_rs1   (id_use_rs1),
      .id_use_rs2   (id_use_rs2),
      .ex_memread   (ex_memread),
      .ex_rd        (ex_rd),
      .ex_redirect  (ex_redirect),
      .ex_mdu_start (ex_mdu_start),
      .mdu_done     (mdu_done),
      .mem_req      (mem_req),
      .mem_ready    (mem_ready),
      .pc_we        (pc_we),
      .if_id_we     (if_id_we),
      .id_ex_we     (id_ex_we),
      .ex_mem_we    (ex_mem_we),
      .mem_wb_we    (mem_wb_we),
      .if_id_flush  (if_id_flush),
      .id_ex_flush  (id_ex_flush),
      .ex_mem_flush (ex_mem_flush),
      .mem_wb_flush (mem_wb_flush),
      .stall_cnt    (stall_cnt),
      .flush_cnt    (flush_cnt)
   );

   sat_counter #(.W(2)) satDut (
      .clk   (clk),
      .rstn  (satRstn),
      .inc   (satInc),
      .count (satCount)
   );

   // Free-running clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Watchdog so the run always ends even if the stimulus stalls.
   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   // Drive one vector just after a rising edge and queue its expectation.
   task automatic applyStimulus(
      input logic r, input logic [4:0] rs1, input logic [4:0] rs2,
      input logic u1, input logic u2, input logic mr, input logic [4:0] rd,
      input logic red, input logic st, input logic dn,
      input logic mq, input logic mrdy,
      input logic [8:0] ec, input logic [31:0] es, input logic [31:0] ef);
      exp_t e;
      @(posedge clk);
      #1;
      rstn         = r;
      id_rs1       = rs1;
      id_rs2       = rs2;
      id_use_rs1   = u1;
      id_use_rs2   = u2;
      ex_memread   = mr;
      ex_rd        = rd;
      ex_redirect  = red;
      ex_mdu_start = st;
      mdu_done     = dn;
      mem_req      = mq;
      mem_ready    = mrdy;
      vecIdx       = vecIdx + 1;
      e.id         = vecIdx;
      e.ctrl       = ec;
      e.stall      = es;
      e.flush      = ef;
      expQ.push_back(e);
      vecValid     = 1'b1;
   endtask

   // Compare one observed value against its expectation.
   task automatic checkOutput(input string name, input int id,
                              input logic [31:0] got, input logic [31:0] want);
      checks = checks + 1;
      if (got !== want) begin
         errors = errors + 1;
         $display("[TB] FAIL vec%0d %s: got %0h expected %0h", id, name, got, want);
      end
   endtask

   // Monitor: pops the scoreboard whenever a vector is presented.
   always @(negedge clk) begin
      exp_t e;
      logic [8:0] ctrl;
      if (vecValid) begin
         if (expQ.size() == 0) begin
            checkOutput("scoreboard_underflow", vecIdx, 32'd1, 32'd0);
         end else begin
            e = expQ.pop_front();
            ctrl = {pc_we, if_id_we, id_ex_we, ex_mem_we, mem_wb_we,
                    if_id_flush, id_ex_flush, ex_mem_flush, mem_wb_flush};
            checkOutput("ctrl", e.id, {23'd0, ctrl}, {23'd0, e.ctrl});
            checkOutput("stall_cnt", e.id, stall_cnt, e.stall);
            checkOutput("flush_cnt", e.id, flush_cnt, e.flush);
         end
      end
      if (satValid) begin
         if (satQ.size() == 0) begin
            checkOutput("sat_underflow", vecIdx, 32'd1, 32'd0);
         end else begin
            checkOutput("sat_count", 0, {30'd0, satCount}, {30'd0, satQ.pop_front()});
         end
      end
   end

   // Directed scenario sequence with hand-computed expectations.
   initial begin
      errors = 0; checks = 0; vecIdx = 0;
      vecValid = 1'b0; satValid = 1'b0;
      satRstn = 1'b0; satInc = 1'b0;
      rstn = 1'b0; id_rs1 = '0; id_rs2 = '0; id_use_rs1 = 1'b0; id_use_rs2 = 1'b0;
      ex_memread = 1'b0; ex_rd = '0; ex_redirect = 1'b0; ex_mdu_start = 1'b0;
      mdu_done = 1'b0; mem_req = 1'b0; mem_ready = 1'b1;

      //             rstn rs1 rs2 u1 u2 mr rd red st dn mq rdy exp   stall flush
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST,  0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 0, 0);
      // load x5, ID reads x5 through rs1
      applyStimulus(1, 5, 0, 1, 0, 1, 5, 0, 0, 0, 0, 1, LU,   0, 0);
      applyStimulus(1, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 1, 0);
      // load x0, ID reads x0: no stall
      applyStimulus(1, 0, 0, 1, 0, 1, 0, 0, 0, 0, 0, 1, NORM, 1, 0);
      // rs2 matches but is not used
      applyStimulus(1, 0, 7, 0, 0, 1, 7, 0, 0, 0, 0, 1, NORM, 1, 0);
      // rs2 matches and is used
      applyStimulus(1, 0, 7, 0, 1, 1, 7, 0, 0, 0, 0, 1, LU,   1, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 2, 0);
      // MUL/DIV, done three cycles after start
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, MDU,  2, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDU,  3, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDU,  4, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, NORM, 5, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 5, 0);
      // redirect coincident with a load-use match
      applyStimulus(1, 9, 0, 1, 0, 1, 9, 1, 0, 0, 0, 1, RED,  5, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 5, 1);
      // memory wait two cycles with redirect held, applied on third
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, MEMW, 5, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, MEMW, 6, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, RED,  7, 1);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 7, 2);
      // start and done together: single-cycle op
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, NORM, 7, 2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 7, 2);
      // MDU wait overlapped by memory wait; done consumed during freeze
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, MDU,  7, 2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, MEMW, 8, 2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, MEMW, 9, 2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 10, 2);
      // enter MDU_WAIT, then reset in the middle of it
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 1, MDU,  10, 2);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, MDU,  11, 2);
      applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, RST,  0, 0);
      // late mdu_done after reset is ignored
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, NORM, 0, 0);
      applyStimulus(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, NORM, 0, 0);
      @(posedge clk);
      #1;
      vecValid = 1'b0;

      // Saturation of a 2-bit counter: 0,1,2,3 then stays at 3.
      satRstn = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(posedge clk);
         #1;
         satInc = 1'b1;
         satQ.push_back((i < 3) ? 2'(i) : 2'd3);
         satValid = 1'b1;
      end
      @(posedge clk);
      #1;
      satValid = 1'b0;
      satInc = 1'b0;

      repeat (2) @(posedge clk);
      checkOutput("queue_drained", 0, 32'(expQ.size() + satQ.size()), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
